inst_fetch_stage: RTL and testbench
===================================

Name: inst_fetch_stage

Overview:
- Instruction-fetch stage placed directly upstream of the asynchronous instruction ROM.
- Holds the PC and drives the ROM word address. Captures the returned instruction into an IF/ID output register.
- Hands the instruction to decode over a valid/allowin handshake, and redirects the PC on taken jumps and branches.
- Single clock domain: clk. Reset resetn is asynchronous and active-low.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset. Must be word-aligned.
- ROM_AW, 5, ROM word-address width. rom_addr = pc[ROM_AW+1:2].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- rom_addr  out  ROM_AW  word address to the instruction ROM. Combinational from the PC register.
- rom_inst  in  32  instruction from the ROM. Valid in the same cycle as rom_addr.
- id_allowin  in  1  decode can accept the IF/ID contents this cycle.
- jbr_taken  in  1  taken jump/branch, raised by decode while it consumes a branch.
- jbr_target  in  32  redirect PC.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_pc  out  32  PC of the held instruction.
- if_inst  out  32  held instruction.
- addr_err  out  1  sticky flag: a misaligned jbr_target was received.
- fetch_cnt  out  32  number of instructions handed to decode.

Behaviour:
- Reset, asserted at any time including mid-stall:
  - pc = RESET_PC.
  - state = BOOT.
  - if_valid = 0, if_pc = 0, if_inst = 0.
  - addr_err = 0, fetch_cnt = 0.
- FSM states and transitions:
  - BOOT: one cycle after resetn deasserts, no capture. Then RUN.
  - RUN: normal fetch.
  - No other states.
- Definitions:
  - fire = if_valid & id_allowin (decode consumes IF/ID this cycle).
  - accept = state==RUN & (!if_valid | id_allowin).
  - redirect = fire & jbr_taken. jbr_taken with fire=0 is ignored.
- Accept without redirect:
  - if_valid <= 1, if_pc <= pc, if_inst <= rom_inst.
  - pc <= pc + 4, 32-bit wrap from FFFF_FFFC to 0000_0000.
- No accept: pc and the IF/ID register hold (stall). rom_addr stays stable.
- Redirect:
  - pc <= {jbr_target[31:2], 2'b00}.
  - The word currently fetched (branch PC + 4) is handled per IF_DELAY_SLOT_EN.
  - If jbr_target[1:0] != 0: addr_err <= 1 and stays set until reset. Fetch continues from the aligned target.
- fetch_cnt increments by 1 on every fire and wraps at 2^32.
- Latency:
  - An instruction appears on if_inst one cycle after its PC is on rom_addr.
  - A new target's instruction appears on if_inst one cycle after the redirect edge.
- ROM aliasing: PC bits above ROM_AW+1 are not decoded. The ROM returns 0 for unused words; fetch does not check this.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot): on redirect, the word at branch PC + 4 is captured.
  - if_valid <= 1, if_pc <= pc, if_inst <= rom_inst.
  - pc <= target.
- Undefined: on redirect, that word is squashed.
  - if_valid <= 0, pc <= target.
  - The target's instruction is captured on the following cycle.

Test Plan:
- Reset, then release:
  - BOOT cycle: rom_addr=0, if_valid=0.
  - Next edge: if_pc=0, if_inst=24010001 (addiu), if_valid=1.
  - rom_addr steps 0,1,2,... while id_allowin=1.
- Stall: hold id_allowin=0 for 3 cycles while if_pc=0x08.
  - if_inst stays 00411821 and rom_addr stays 3.
  - Release: if_pc=0x0C on the next edge. fetch_cnt counts only fires.
- Redirect, macro off: jbr_taken=1 with jbr_target=0x34 while firing if_pc=0x2C.
  - Next cycle: if_valid=0.
  - Following cycle: if_pc=0x34, if_inst=8C2A0013.
- Redirect, macro on: same stimulus.
  - Next cycle: if_pc=0x30, if_inst=24010004, if_valid=1.
  - Following cycle: if_pc=0x34.
- Misaligned target: jbr_target=0x0000_0036.
  - addr_err=1, fetch resumes at 0x34.
  - jbr_taken with id_allowin=0 has no effect.
- Asynchronous reset mid-stall (if_valid=1, pc=0x48):
  - All outputs clear immediately, without waiting for a clock edge.
  - After release: BOOT, then fetch from 0.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the async instruction ROM and
// registers the fetched word into IF/ID. Optional branch delay slot: IF_DELAY_SLOT_EN.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 5
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              id_allowin,
  input  logic              jbr_taken,
  input  logic [31:0]       jbr_target,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              addr_err,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q,       pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q,    if_pc_d;
  logic [31:0] if_inst_q,  if_inst_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] cnt_q,      cnt_d;

  logic fire;
  logic accept;
  logic redirect;

  assign fire     = if_valid_q & id_allowin;
  assign accept   = (state_q == ST_RUN) & (~if_valid_q | id_allowin);
  assign redirect = fire & jbr_taken;

  // Upper PC bits are deliberately not decoded; the ROM aliases.
  assign rom_addr  = pc_q[ROM_AW+1:2];
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign addr_err  = addr_err_q;
  assign fetch_cnt = cnt_q;

  always_comb begin
    // NOTE: every next-state value defaults to its hold value first, so no path leaves one unassigned and no latch is inferred.
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    addr_err_d = addr_err_q;
    cnt_d      = cnt_q;

    if (redirect) begin
      pc_d = {jbr_target[31:2], 2'b00};
      if (jbr_target[1:0] != 2'b00) addr_err_d = 1'b1;
`ifdef IF_DELAY_SLOT_EN
      // The word after the branch is the delay slot and still issues.
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_inst_d  = rom_inst;
`else
      // The word after the branch is squashed; the target is fetched next cycle.
      if_valid_d = 1'b0;
`endif
    end else if (accept) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_inst_d  = rom_inst;
      pc_d       = pc_q + 32'd4;
    end

    if (fire) cnt_d = cnt_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
      addr_err_q <= 1'b0;
      cnt_q      <= 32'h0;
    end else begin
      state_q    <= ST_RUN;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      addr_err_q <= addr_err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: a transaction-level fetch model is
// compared every cycle, plus hand-computed literal checkpoints.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        id_allowin;
  logic        jbr_taken;
  logic [31:0] jbr_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  logic [31:0] rom [32];
  assign rom_inst = rom[rom_addr];

  inst_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (5)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst),
    .id_allowin (id_allowin),
    .jbr_taken  (jbr_taken),
    .jbr_target (jbr_target),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .addr_err   (addr_err),
    .fetch_cnt  (fetch_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: next word to fetch, the one slot handed to decode, and counters.
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_inst;
  bit          m_err;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_boot  = 1'b1;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_ifpc  = 32'h0;
    m_inst  = 32'h0;
    m_err   = 1'b0;
    m_cnt   = 32'h0;
  endfunction

  function automatic void take_word();
    m_valid = 1'b1;
    m_ifpc  = m_pc;
    m_inst  = rom[m_pc[6:2]];
  endfunction

  // Applies one rising edge to the model using the inputs present at that edge.
  function automatic void model_edge();
    bit handed;
    if (!resetn) return;
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    handed = m_valid && id_allowin;
    if (handed) m_cnt = m_cnt + 32'd1;
    if (handed && jbr_taken) begin
      if (jbr_target[1:0] != 2'b00) m_err = 1'b1;
`ifdef IF_DELAY_SLOT_EN
      take_word();
`else
      m_valid = 1'b0;
`endif
      m_pc = jbr_target & 32'hFFFF_FFFC;
    end else if (!m_valid || id_allowin) begin
      take_word();
      m_pc = m_pc + 32'd4;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rom_addr",  32'(rom_addr), {27'b0, m_pc[6:2]});
      check("if_valid",  32'(if_valid), 32'(m_valid));
      check("if_pc",     if_pc,         m_ifpc);
      check("if_inst",   if_inst,       m_inst);
      check("addr_err",  32'(addr_err), 32'(m_err));
      check("fetch_cnt", fetch_cnt,     m_cnt);
    end
  end

  task automatic tick(input logic a, input logic t, input logic [31:0] tg);
    id_allowin = a;
    jbr_taken  = t;
    jbr_target = tg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " rom_addr"},  32'(rom_addr), 32'h0);
    check({tag, " if_valid"},  32'(if_valid), 32'h0);
    check({tag, " if_pc"},     if_pc,         32'h0);
    check({tag, " if_inst"},   if_inst,       32'h0);
    check({tag, " addr_err"},  32'(addr_err), 32'h0);
    check({tag, " fetch_cnt"}, fetch_cnt,     32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h2401_0001 + i;
    rom[2]  = 32'h0041_1821;
    rom[12] = 32'h2401_0004;
    rom[13] = 32'h8C2A_0013;

    resetn     = 1'b0;
    id_allowin = 1'b0;
    jbr_taken  = 1'b0;
    jbr_target = 32'h0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 32'h0);
    check_cleared("reset");

    // Release: BOOT cycle, then first capture one edge later.
    resetn = 1'b1;
    check("boot rom_addr", 32'(rom_addr), 32'h0);
    check("boot if_valid", 32'(if_valid), 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("post-boot if_valid", 32'(if_valid), 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("first if_pc",    if_pc,          32'h0);
    check("first if_inst",  if_inst,        32'h2401_0001);
    check("first if_valid", 32'(if_valid),  32'h1);
    check("first rom_addr", 32'(rom_addr),  32'h1);
    repeat (2) tick(1'b1, 1'b0, 32'h0);
    check("pre-stall if_pc", if_pc,     32'h08);
    check("pre-stall cnt",   fetch_cnt, 32'd2);

    // Stall three cycles while holding PC 0x08.
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    check("stall if_inst",  if_inst,        32'h0041_1821);
    check("stall rom_addr", 32'(rom_addr),  32'h3);
    check("stall cnt",      fetch_cnt,      32'd2);
    tick(1'b1, 1'b0, 32'h0);
    check("unstall if_pc", if_pc,     32'h0C);
    check("unstall cnt",   fetch_cnt, 32'd3);

    repeat (8) tick(1'b1, 1'b0, 32'h0);
    check("pre-branch if_pc", if_pc,     32'h2C);
    check("pre-branch cnt",   fetch_cnt, 32'd11);

    // Taken branch consumed while IF/ID holds 0x2C.
    tick(1'b1, 1'b1, 32'h34);
`ifdef IF_DELAY_SLOT_EN
    check("slot if_valid", 32'(if_valid), 32'h1);
    check("slot if_pc",    if_pc,         32'h30);
    check("slot if_inst",  if_inst,       32'h2401_0004);
`else
    check("squash if_valid", 32'(if_valid), 32'h0);
    check("squash rom_addr", 32'(rom_addr), 32'd13);
`endif
    check("branch cnt", fetch_cnt, 32'd12);
    tick(1'b1, 1'b0, 32'h0);
    check("target if_pc",   if_pc,   32'h34);
    check("target if_inst", if_inst, 32'h8C2A_0013);

    // jbr_taken without a fire is ignored.
    tick(1'b0, 1'b1, 32'h10);
    check("ignored if_pc",    if_pc,         32'h34);
    check("ignored rom_addr", 32'(rom_addr), 32'd14);
    check("ignored addr_err", 32'(addr_err), 32'h0);

    // Misaligned target: sticky error, resume at aligned 0x34.
    tick(1'b1, 1'b1, 32'h36);
    check("misalign addr_err", 32'(addr_err), 32'h1);
    tick(1'b1, 1'b0, 32'h0);
    check("misalign if_pc",    if_pc,         32'h34);
    check("misalign rom_addr", 32'(rom_addr), 32'd14);
    check("sticky addr_err",   32'(addr_err), 32'h1);

    // Run to IF/ID=0x44, pc=0x48, then stall and reset asynchronously.
    repeat (4) tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check("mid-stall if_valid", 32'(if_valid), 32'h1);
    check("mid-stall rom_addr", 32'(rom_addr), 32'd18);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    check_cleared("async reset");
    @(negedge clk);
    #1;
    tick(1'b0, 1'b0, 32'h0);
    resetn = 1'b1;
    check("reboot rom_addr", 32'(rom_addr), 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("reboot if_valid", 32'(if_valid), 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("refetch if_pc",   if_pc,   32'h0);
    check("refetch if_inst", if_inst, 32'h2401_0001);

    // PC wrap from FFFF_FFFC to 0, with ROM aliasing of the high addresses.
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (2) tick(1'b1, 1'b0, 32'h0);
    check("wrap if_pc",    if_pc,         32'hFFFF_FFFC);
    check("wrap if_inst",  if_inst,       32'h2401_0020);
    check("wrap rom_addr", 32'(rom_addr), 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("wrapped if_pc",    if_pc,         32'h0);
    check("wrapped rom_addr", 32'(rom_addr), 32'h1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
